program_loader: RTL and testbench
=================================

# program_loader

Boot-time instruction source sitting directly upstream of the CPU. Accepts a byte stream over a valid/ready handshake, assembles bytes into instruction words, writes them into an internal instruction memory, and serves `instruction` to the CPU for any `pc`. Holds the CPU in reset while a program is loading and releases it once the final word is stored.

## Interface

Parameters:
- `PC_WIDTH`, default 8: address width; memory depth is 2^PC_WIDTH words.
- `INSTRUCTION_WIDTH`, default 16: word width; must be a multiple of 8. BYTES_PER_WORD = INSTRUCTION_WIDTH/8.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `isReset` in 1: reset, synchronous, active-high.
- `inByte` in 8: load stream data.
- `inValid` in 1: `inByte` is valid.
- `inReady` out 1: loader can accept a byte; transfer occurs when `inValid && inReady` at the clock edge.
- `pc` in PC_WIDTH: CPU fetch address.
- `instruction` out INSTRUCTION_WIDTH: mem[pc], combinational read.
- `cpuReset` out 1: drives the CPU's `isReset`; high while loading.
- `loadError` out 1: checksum failure (see Configuration).

## Operation

- States: COUNT_LO, COUNT_HI, DATA, CHECK (only with the macro), RUN, ERROR (only with the macro).
- Stream format: 16-bit word count N, little-endian (COUNT_LO, then COUNT_HI). Then N×BYTES_PER_WORD data bytes, each word little-endian (first byte lands in bits [7:0]).
- COUNT_LO → COUNT_HI on accept. COUNT_HI → DATA on accept if N≠0. If N=0: → RUN (→ CHECK with the macro).
- DATA: byte index counter 0..BYTES_PER_WORD-1 fills a shift/assembly register. The accept of the final byte of a word writes the assembled word to mem[writeAddr], increments writeAddr, and increments wordCount. When wordCount reaches N → RUN (→ CHECK with the macro).
- writeAddr wraps modulo 2^PC_WIDTH. If N > depth, later words overwrite earlier ones. This is intentional and not an error.
- RUN: `inReady`=0 and bytes are ignored. Only `isReset` starts a new load.
- Memory contents are not cleared by `isReset`. Unwritten locations read as X.
- `inReady`=1 in COUNT_LO, COUNT_HI, DATA and CHECK; 0 in RUN and ERROR; forced to 0 while `isReset` is high.
- `cpuReset` is registered: 1 in every state except RUN.

## Timing

- Reset values: state=COUNT_LO, byte index=0, writeAddr=0, wordCount=0, `cpuReset`=1, `loadError`=0, checksum=0x00. `inReady` is high from the first cycle after `isReset` falls.
- One byte per cycle maximum. There are no bubbles between words.
- Write latency: a word written at edge k is visible on `instruction` (for matching `pc`) from cycle k+1.
- `cpuReset` falls at the edge following the edge that accepts the last data byte (or the checksum byte). The CPU therefore starts at the same time as the word is readable.
- `isReset` mid-load: abandons the load at that edge and returns to COUNT_LO. Words already written stay in memory.
- `inValid` low in any state holds all state. There is no timeout.

## Configuration

- `LOADER_CHECKSUM_EN` defined:
  - After the last data byte (or after COUNT_HI when N=0), CHECK accepts one byte.
  - The byte must equal the XOR of all data bytes (0x00 if N=0).
  - Match → RUN.
  - Mismatch → ERROR: `loadError`=1, `cpuReset` stays 1, `inReady`=0, until `isReset`.
- `LOADER_CHECKSUM_EN` undefined:
  - CHECK and ERROR are not built.
  - `loadError` is tied to 0.
  - No checksum byte is expected.

## Structure

- Shared package `loader_pkg`:
  - state enum
  - BYTES_PER_WORD derivation
  - COUNT_WIDTH=16 constant
  - default PC_WIDTH/INSTRUCTION_WIDTH, matching the CPU's
- Sub-module `instruction_ram`: one synchronous write port and one asynchronous read port, depth 2^PC_WIDTH, no reset.

## Test plan

- Reset then stream 02 00 34 12 78 56 → mem[0]=0x1234, mem[1]=0x5678. `cpuReset` falls one edge after byte 0x56 is accepted. `instruction`=0x5678 with pc=1.
- Same stream with `inValid` toggled every other cycle → identical memory contents. `inReady` never drops before RUN.
- Count 00 00 → RUN immediately after COUNT_HI (no macro), or after checksum 00 (macro). Memory is unchanged.
- PC_WIDTH=2, N=5 words 0x0001..0x0005 → mem[0]=0x0005, mem[1..3]=0x0002..0x0004.
- Assert `isReset` after 3 data bytes of a 2-word load → back to COUNT_LO with `cpuReset`=1. Reload with N=1, word 0xBEEF → mem[0]=0xBEEF, then RUN.
- Macro on: 01 00 34 12 26 → RUN. Same stream ending 27 → ERROR, `loadError`=1, `cpuReset`=1 until `isReset`.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared state encoding and sizing constants for program_loader.
// The CHECK/ERROR states exist only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int unsigned COUNT_WIDTH               = 16;
  localparam int unsigned DEFAULT_PC_WIDTH          = 8;
  localparam int unsigned DEFAULT_INSTRUCTION_WIDTH = 16;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {COUNT_LO, COUNT_HI, DATA, CHECK, RUN, ERROR} state_e;
`else
  typedef enum logic [1:0] {COUNT_LO, COUNT_HI, DATA, RUN} state_e;
`endif

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/instruction_ram.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// No reset, so a reload only overwrites the words it actually stores.
module instruction_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Boot loader: byte stream -> instruction memory, holding the CPU in reset while loading.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned PC_WIDTH          = DEFAULT_PC_WIDTH,
  parameter int unsigned INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic [7:0]                   inByte,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [PC_WIDTH-1:0]          pc,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         cpuReset,
  output logic                         loadError
);

  localparam int unsigned BPW   = bytes_per_word(INSTRUCTION_WIDTH);
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = CHECK;
`else
  localparam state_e AFTER_DATA = RUN;
`endif

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             byteIdx_q, byteIdx_d;
  logic [PC_WIDTH-1:0]          writeAddr_q, writeAddr_d;
  logic [COUNT_WIDTH-1:0]       wordCount_q, wordCount_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;
  logic [INSTRUCTION_WIDTH-1:0] asm_q, asm_d;
  logic                         cpuReset_q;
  logic                         accept;
  logic                         ramWe;
  logic [COUNT_WIDTH-1:0]       fullCount;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                   checksum_q, checksum_d;
`endif

  assign accept = inValid && inReady;

  always_ff @(posedge clock) begin
    if (isReset) begin
      state_q     <= COUNT_LO;
      byteIdx_q   <= '0;
      writeAddr_q <= '0;
      wordCount_q <= '0;
      count_q     <= '0;
      asm_q       <= '0;
      cpuReset_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byteIdx_q   <= byteIdx_d;
      writeAddr_q <= writeAddr_d;
      wordCount_q <= wordCount_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      // Lags the state by one edge so the CPU starts once the last word is readable.
      cpuReset_q  <= (state_q != RUN);
`ifdef LOADER_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    byteIdx_d   = byteIdx_q;
    writeAddr_d = writeAddr_q;
    wordCount_d = wordCount_q;
    count_d     = count_q;
    asm_d       = asm_q;
    ramWe       = 1'b0;
    fullCount   = {inByte, count_q[7:0]};
`ifdef LOADER_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    if (accept) begin
      unique case (state_q)
        COUNT_LO: begin
          count_d = COUNT_WIDTH'(inByte);
          state_d = COUNT_HI;
        end
        COUNT_HI: begin
          count_d = fullCount;
          state_d = (fullCount == '0) ? AFTER_DATA : DATA;
        end
        DATA: begin
          asm_d[{byteIdx_q, 3'b000} +: 8] = inByte;
`ifdef LOADER_CHECKSUM_EN
          checksum_d = checksum_q ^ inByte;
`endif
          if (byteIdx_q == LAST_IDX) begin
            byteIdx_d   = '0;
            ramWe       = 1'b1;
            writeAddr_d = writeAddr_q + PC_WIDTH'(1);
            wordCount_d = wordCount_q + COUNT_WIDTH'(1);
            if (wordCount_d == count_q) begin
              state_d = AFTER_DATA;
            end
          end else begin
            byteIdx_d = byteIdx_q + IDX_W'(1);
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: state_d = (inByte == checksum_q) ? RUN : ERROR;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (state_q)
      COUNT_LO, COUNT_HI, DATA: inReady = !isReset;
`ifdef LOADER_CHECKSUM_EN
      CHECK:                    inReady = !isReset;
`endif
      default:                  inReady = 1'b0;
    endcase
    cpuReset = cpuReset_q;
`ifdef LOADER_CHECKSUM_EN
    loadError = (state_q == ERROR);
`else
    loadError = 1'b0;
`endif
  end

  instruction_ram #(
    .ADDR_WIDTH (PC_WIDTH),
    .DATA_WIDTH (INSTRUCTION_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (ramWe),
    .waddr (writeAddr_q),
    .wdata (asm_d),
    .raddr (pc),
    .rdata (instruction)
  );

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader against a word-level memory model.
// Checksum scenarios are exercised when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  localparam int unsigned PCW   = 8;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 1 << PCW;

  logic           clock    = 1'b0;
  logic           isReset  = 1'b1;
  logic [7:0]     inByte   = '0;
  logic           inValid  = 1'b0;
  logic [PCW-1:0] pc       = '0;
  logic           inReady;
  logic [IW-1:0]  instruction;
  logic           cpuReset;
  logic           loadError;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [IW-1:0] model_mem   [DEPTH];
  bit            model_valid [DEPTH];

  always #5 clock = ~clock;

  program_loader #(
    .PC_WIDTH          (PCW),
    .INSTRUCTION_WIDTH (IW)
  ) dut (
    .clock       (clock),
    .isReset     (isReset),
    .inByte      (inByte),
    .inValid     (inValid),
    .inReady     (inReady),
    .pc          (pc),
    .instruction (instruction),
    .cpuReset    (cpuReset),
    .loadError   (loadError)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clock);
    isReset = 1'b1;
    inValid = 1'b0;
    repeat (2) @(negedge clock);
    isReset = 1'b0;
  endtask

  // Offers one byte after gap_lo..gap_hi idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap_lo,
                           input int unsigned gap_hi, input string tag);
    int unsigned g;
    g = $urandom_range(gap_hi, gap_lo);
    repeat (g) begin
      @(negedge clock);
      inValid = 1'b0;
      inByte  = 8'($urandom);
    end
    @(negedge clock);
    inValid = 1'b1;
    inByte  = b;
    n_cmp++;
    if (inReady !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready: inReady=%b expected 1 (byte %h)", tag, inReady, b);
    end
    @(posedge clock);
  endtask

  task automatic check_mem(input string tag);
    for (int unsigned a = 0; a < DEPTH; a++) begin
      if (model_valid[a]) begin
        pc = PCW'(a);
        #1;
        n_cmp++;
        if (instruction !== model_mem[a]) begin
          n_bad++;
          $display("FAIL %s_mem[%0d]: got %h expected %h", tag, a, instruction, model_mem[a]);
        end
      end
    end
  endtask

  task automatic run_load(input logic [IW-1:0] words[$], input int unsigned gap_lo,
                          input int unsigned gap_hi, input bit corrupt, input string tag);
    logic [15:0] n;
    logic [7:0]  cks;
    logic [7:0]  b;
    logic [IW-1:0] w;
    bit          exp_err;
    n   = 16'(words.size());
    cks = '0;
    send_byte(n[7:0], gap_lo, gap_hi, tag);
    send_byte(n[15:8], gap_lo, gap_hi, tag);
    for (int i = 0; i < int'(n); i++) begin
      w = words[i];
      for (int j = 0; j < int'(IW / 8); j++) begin
        b   = w[j*8 +: 8];
        cks = cks ^ b;
        send_byte(b, gap_lo, gap_hi, tag);
      end
      model_mem[i % DEPTH]   = w;
      model_valid[i % DEPTH] = 1'b1;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(corrupt ? (cks ^ 8'h01) : cks, gap_lo, gap_hi, tag);
    exp_err = corrupt;
`else
    exp_err = 1'b0;
`endif
    @(negedge clock);
    inValid = 1'b1;
    inByte  = 8'hA5;
    n_cmp += 3;
    if (inReady !== 1'b0) begin
      n_bad++; $display("FAIL %s_done_ready: inReady=%b expected 0", tag, inReady);
    end
    if (cpuReset !== 1'b1) begin
      n_bad++; $display("FAIL %s_cpureset_lag: cpuReset=%b expected 1", tag, cpuReset);
    end
    if (loadError !== exp_err) begin
      n_bad++; $display("FAIL %s_loaderror: loadError=%b expected %b", tag, loadError, exp_err);
    end
    repeat (2) @(negedge clock);
    inValid = 1'b0;
    n_cmp += 2;
    if (cpuReset !== exp_err) begin
      n_bad++; $display("FAIL %s_cpureset: cpuReset=%b expected %b", tag, cpuReset, exp_err);
    end
    if (loadError !== exp_err) begin
      n_bad++; $display("FAIL %s_loaderror_hold: loadError=%b expected %b", tag, loadError, exp_err);
    end
    check_mem(tag);
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_cmp += 3;
    if (inReady !== 1'b0) begin n_bad++; $display("FAIL reset_ready: inReady=%b expected 0", inReady); end
    if (cpuReset !== 1'b1) begin n_bad++; $display("FAIL reset_cpu: cpuReset=%b expected 1", cpuReset); end
    if (loadError !== 1'b0) begin n_bad++; $display("FAIL reset_err: loadError=%b expected 0", loadError); end
    isReset = 1'b0;
    #1;
    n_cmp += 2;
    if (inReady !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: inReady=%b expected 1", inReady); end
    if (cpuReset !== 1'b1) begin n_bad++; $display("FAIL reset_release_cpu: cpuReset=%b expected 1", cpuReset); end
  endtask

  task automatic test_basic();
    logic [IW-1:0] q[$];
    q = '{16'h1234, 16'h5678};
    run_load(q, 0, 0, 1'b0, "basic");
    pc = 8'd1;
    #1;
    n_cmp++;
    if (instruction !== 16'h5678) begin
      n_bad++; $display("FAIL basic_pc1: instruction=%h expected 5678", instruction);
    end
  endtask

  task automatic test_gaps();
    logic [IW-1:0] q[$];
    do_reset();
    q = '{16'hAAAA, 16'h5555};
    run_load(q, 0, 0, 1'b0, "gaps_pre");
    do_reset();
    q = '{16'h1234, 16'h5678};
    run_load(q, 1, 1, 1'b0, "gaps");
  endtask

  task automatic test_zero_count();
    logic [IW-1:0] q[$];
    do_reset();
    q = {};
    run_load(q, 0, 2, 1'b0, "zero");
  endtask

  task automatic test_wrap();
    logic [IW-1:0] q[$];
    do_reset();
    q = {};
    for (int i = 0; i < int'(DEPTH) + 5; i++) q.push_back(IW'($urandom));
    run_load(q, 0, 0, 1'b0, "wrap");
  endtask

  task automatic test_abort();
    logic [IW-1:0] q[$];
    do_reset();
    send_byte(8'h02, 0, 0, "abort");
    send_byte(8'h00, 0, 0, "abort");
    send_byte(8'hAA, 0, 0, "abort");
    send_byte(8'hBB, 0, 0, "abort");
    send_byte(8'hCC, 0, 0, "abort");
    model_mem[0]   = 16'hBBAA;
    model_valid[0] = 1'b1;
    @(negedge clock);
    isReset = 1'b1;
    inValid = 1'b0;
    @(negedge clock);
    isReset = 1'b0;
    #1;
    n_cmp += 2;
    if (inReady !== 1'b1) begin n_bad++; $display("FAIL abort_ready: inReady=%b expected 1", inReady); end
    if (cpuReset !== 1'b1) begin n_bad++; $display("FAIL abort_cpu: cpuReset=%b expected 1", cpuReset); end
    check_mem("abort_keep");
    q = '{16'hBEEF};
    run_load(q, 0, 1, 1'b0, "reload");
  endtask

  task automatic test_random(input int unsigned iters, input int unsigned gap_hi, input string tag);
    logic [IW-1:0] q[$];
    for (int unsigned k = 0; k < iters; k++) begin
      do_reset();
      q = {};
      for (int unsigned i = 0; i < $urandom_range(24, 1); i++) q.push_back(IW'($urandom));
      run_load(q, 0, gap_hi, 1'b0, tag);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [IW-1:0] q[$];
    do_reset();
    q = '{16'h1234};
    run_load(q, 0, 0, 1'b0, "cks_good");
    do_reset();
    run_load(q, 0, 0, 1'b1, "cks_bad");
    repeat (3) @(negedge clock);
    n_cmp += 3;
    if (loadError !== 1'b1) begin n_bad++; $display("FAIL cks_err_hold: loadError=%b expected 1", loadError); end
    if (cpuReset !== 1'b1) begin n_bad++; $display("FAIL cks_cpu_hold: cpuReset=%b expected 1", cpuReset); end
    if (inReady !== 1'b0) begin n_bad++; $display("FAIL cks_ready_hold: inReady=%b expected 0", inReady); end
    do_reset();
    #1;
    n_cmp += 2;
    if (loadError !== 1'b0) begin n_bad++; $display("FAIL cks_err_clear: loadError=%b expected 0", loadError); end
    if (inReady !== 1'b1) begin n_bad++; $display("FAIL cks_ready_clear: inReady=%b expected 1", inReady); end
  endtask
`endif

  initial begin
    for (int unsigned a = 0; a < DEPTH; a++) model_valid[a] = 1'b0;
    repeat (2) @(posedge clock);
    test_reset();
    test_basic();
    test_gaps();
    test_zero_count();
    test_abort();
    test_random(4, 3, "rand");
    test_random(2, 0, "b2b");
    test_wrap();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
